// File: rtl/candy_sram_bwe.sv
// Single-port-per-direction SRAM model with per-lane byte write enables,
// a pipelined read path of READ_LAT cycles and an optional post-reset zero sweep.
module candy_sram_bwe #(
  parameter int DATA_W         = 24,
  parameter int ADDR_W         = 17,
  parameter int LANE_W         = 8,
  parameter int READ_LAT       = 1,
  parameter int CLEAR_ON_RESET = 1
) (
  input  logic                       clk,
  input  logic                       rst,
  input  logic                       write_enable,
  input  logic [ADDR_W-1:0]          waddr,
  input  logic [DATA_W-1:0]          wdata,
  input  logic [DATA_W/LANE_W-1:0]   wmask,
  input  logic                       read_enable,
  input  logic [ADDR_W-1:0]          raddr,
  output logic [DATA_W-1:0]          rdata,
  output logic                       rdata_ready,
  output logic                       busy
);

  localparam int DEPTH = 2 ** ADDR_W;
  localparam int LANES = DATA_W / LANE_W;
  localparam logic [ADDR_W:0] LAST_ADDR = (ADDR_W + 1)'(DEPTH - 1);

  typedef enum logic {IDLE, CLEAR} state_t;

  state_t              state;
  logic [ADDR_W:0]     clr_cnt;
  logic [DATA_W-1:0]   mem [DEPTH];
  logic                wr_acc;
  logic                rd_acc;
  logic [DATA_W-1:0]   rd_word;
  logic [READ_LAT-1:0] pipe_vld;
  logic [DATA_W-1:0]   pipe_data [READ_LAT];

  assign wr_acc = write_enable && !busy && !rst;
  assign rd_acc = read_enable && !busy && !rst;

  // Write-first: a same-cycle write to the read address is merged into the read word.
  always_comb begin
    // NOTE: default assignment first so every path drives rd_word and no latch is inferred.
    rd_word = mem[raddr];
    if (wr_acc && (waddr == raddr)) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) rd_word[i*LANE_W +: LANE_W] = wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Clear sweep: one address per cycle, terminal compare avoids relying on wrap.
  always_ff @(posedge clk) begin
    // NOTE: sequential state uses non-blocking assignments only, so all flops update together.
    if (rst) begin
      state   <= (CLEAR_ON_RESET != 0) ? CLEAR : IDLE;
      busy    <= (CLEAR_ON_RESET != 0);
      clr_cnt <= '0;
    end else begin
      case (state)
        IDLE: ;
        CLEAR: begin
          if (clr_cnt == LAST_ADDR) begin
            state <= IDLE;
            busy  <= 1'b0;
          end else begin
            clr_cnt <= clr_cnt + (ADDR_W + 1)'(1);
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

  // NOTE: the array has no reset term; contents are only zeroed by the sweep, which keeps it mappable to SRAM.
  always_ff @(posedge clk) begin
    if (!rst && (state == CLEAR)) begin
      mem[clr_cnt[ADDR_W-1:0]] <= '0;
    end else if (wr_acc) begin
      for (int i = 0; i < LANES; i++) begin
        if (wmask[i]) mem[waddr][i*LANE_W +: LANE_W] <= wdata[i*LANE_W +: LANE_W];
      end
    end
  end

  // Each stage only loads when its predecessor is valid, so the last stage holds rdata between pulses.
  always_ff @(posedge clk) begin
    if (rst) begin
      pipe_vld <= '0;
      for (int i = 0; i < READ_LAT; i++) pipe_data[i] <= '0;
    end else begin
      pipe_vld[0] <= rd_acc;
      if (rd_acc) pipe_data[0] <= rd_word;
      for (int i = 1; i < READ_LAT; i++) begin
        pipe_vld[i] <= pipe_vld[i-1];
        if (pipe_vld[i-1]) pipe_data[i] <= pipe_data[i-1];
      end
    end
  end

  assign rdata       = pipe_data[READ_LAT-1];
  assign rdata_ready = pipe_vld[READ_LAT-1];

endmodule

// File: tb/tb_candy_sram_bwe.sv
// Scoreboard bench for candy_sram_bwe: a reference memory model predicts every
// read result and the cycle its ready pulse must appear.
module tb_candy_sram_bwe;

  localparam int AW    = 4;
  localparam int DW    = 24;
  localparam int LW    = 8;
  localparam int RL    = 2;
  localparam int NL    = DW / LW;
  localparam int DEPTH = 2 ** AW;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          write_enable = 1'b0;
  logic [AW-1:0] waddr = '0;
  logic [DW-1:0] wdata = '0;
  logic [NL-1:0] wmask = '0;
  logic          read_enable = 1'b0;
  logic [AW-1:0] raddr = '0;
  logic [DW-1:0] rdata;
  logic          rdata_ready;
  logic          busy;

  candy_sram_bwe #(
    .DATA_W(DW), .ADDR_W(AW), .LANE_W(LW), .READ_LAT(RL), .CLEAR_ON_RESET(1)
  ) dut (
    .clk(clk), .rst(rst),
    .write_enable(write_enable), .waddr(waddr), .wdata(wdata), .wmask(wmask),
    .read_enable(read_enable), .raddr(raddr),
    .rdata(rdata), .rdata_ready(rdata_ready), .busy(busy)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [DW-1:0] data;
    int            due;
  } exp_t;

  exp_t          sb[$];
  exp_t          mon_e;
  logic [DW-1:0] model [DEPTH];
  logic [DW-1:0] last_rdata = '0;
  int            cyc = 0;
  int            checks = 0;
  int            failures = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Every ready pulse must match the oldest outstanding read, in data and timing.
  always @(negedge clk) begin
    if (rdata_ready === 1'b1) begin
      checks++;
      if (sb.size() == 0) begin
        failures++;
        $display("FAIL unexpected_ready: got ready=1 rdata=%h at cycle %0d, required no pulse", rdata, cyc);
      end else begin
        mon_e = sb.pop_front();
        last_rdata = mon_e.data;
        if (rdata !== mon_e.data || cyc != mon_e.due) begin
          failures++;
          $display("FAIL read_result: got rdata=%h at cycle %0d, required %h at cycle %0d",
                   rdata, cyc, mon_e.data, mon_e.due);
        end
      end
    end
  end

  function automatic logic [DW-1:0] merge(input logic [DW-1:0] old, input logic [DW-1:0] wd,
                                          input logic [NL-1:0] wm);
    logic [DW-1:0] r;
    r = old;
    for (int i = 0; i < NL; i++) if (wm[i]) r[i*LW +: LW] = wd[i*LW +: LW];
    return r;
  endfunction

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  // One request cycle; the model is updated write-first like the DUT.
  task automatic op(input logic we, input logic [AW-1:0] wa, input logic [DW-1:0] wd,
                    input logic [NL-1:0] wm, input logic re, input logic [AW-1:0] ra);
    exp_t e;
    write_enable = we; waddr = wa; wdata = wd; wmask = wm;
    read_enable  = re; raddr = ra;
    if (re) begin
      e.data = model[ra];
      if (we && wa == ra) e.data = merge(e.data, wd, wm);
      e.due = cyc + RL;
      sb.push_back(e);
    end
    if (we) model[wa] = merge(model[wa], wd, wm);
    idle(1);
    write_enable = 1'b0;
    read_enable  = 1'b0;
  endtask

  task automatic drain();
    int n = 0;
    while (sb.size() != 0 && n < 20) begin
      idle(1);
      n++;
    end
    checks++;
    if (sb.size() != 0) begin
      failures++;
      $display("FAIL drain: got %0d reads still outstanding, required 0", sb.size());
    end
    sb.delete();
  endtask

  task automatic do_reset();
    sb.delete();
    rst = 1'b1;
    idle(2);
    checks++;
    if (rdata !== '0 || rdata_ready !== 1'b0 || busy !== 1'b1) begin
      failures++;
      $display("FAIL reset_outputs: got rdata=%h ready=%b busy=%b, required 000000 0 1",
               rdata, rdata_ready, busy);
    end
    rst = 1'b0;
  endtask

  task automatic count_busy(input int expected);
    int n = 0;
    while (busy === 1'b1 && n < 40) begin
      n++;
      idle(1);
    end
    checks++;
    if (n != expected || busy !== 1'b0) begin
      failures++;
      $display("FAIL busy_length: got %0d busy cycles (busy now %b), required %0d", n, busy, expected);
    end
    for (int i = 0; i < DEPTH; i++) model[i] = '0;
  endtask

  task automatic test_reset();
    do_reset();
    count_busy(16);
    op(1'b0, '0, '0, '0, 1'b1, 4'd5);
    drain();
  endtask

  task automatic test_write_read();
    op(1'b1, 4'd0, 24'h001234, 3'b111, 1'b0, '0);
    op(1'b0, '0, '0, '0, 1'b1, 4'd0);
    op(1'b1, 4'd0, 24'hAB0000, 3'b100, 1'b0, '0);
    op(1'b0, '0, '0, '0, 1'b1, 4'd0);
    op(1'b1, 4'd7, 24'h5A5A5A, 3'b000, 1'b0, '0);
    op(1'b0, '0, '0, '0, 1'b1, 4'd7);
    drain();
  endtask

  task automatic test_same_cycle();
    op(1'b1, 4'd3, 24'h00CC00, 3'b010, 1'b1, 4'd3);
    op(1'b1, 4'd3, 24'hAAAAAA, 3'b111, 1'b0, '0);
    op(1'b1, 4'd3, 24'h001100, 3'b010, 1'b1, 4'd3);
    op(1'b0, '0, '0, '0, 1'b1, 4'd3);
    drain();
  endtask

  task automatic test_back_to_back();
    op(1'b1, 4'd0, 24'h000011, 3'b111, 1'b0, '0);
    op(1'b1, 4'd1, 24'h000022, 3'b111, 1'b0, '0);
    op(1'b1, 4'd2, 24'h000033, 3'b111, 1'b0, '0);
    op(1'b0, '0, '0, '0, 1'b1, 4'd0);
    op(1'b0, '0, '0, '0, 1'b1, 4'd1);
    op(1'b0, '0, '0, '0, 1'b1, 4'd2);
    drain();
  endtask

  task automatic test_hold();
    for (int i = 0; i < 3; i++) begin
      idle(1);
      checks++;
      if (rdata !== last_rdata || rdata_ready !== 1'b0) begin
        failures++;
        $display("FAIL rdata_hold: got rdata=%h ready=%b, required %h 0", rdata, rdata_ready, last_rdata);
      end
    end
  endtask

  task automatic test_busy_drop();
    do_reset();
    idle(4);
    write_enable = 1'b1; waddr = 4'd1; wdata = 24'hFFFFFF; wmask = 3'b111;
    read_enable  = 1'b1; raddr = 4'd1;
    idle(1);
    write_enable = 1'b0;
    read_enable  = 1'b0;
    count_busy(11);
    op(1'b0, '0, '0, '0, 1'b1, 4'd1);
    drain();
  endtask

  task automatic test_reset_inflight();
    op(1'b1, 4'd2, 24'h123456, 3'b111, 1'b0, '0);
    op(1'b0, '0, '0, '0, 1'b1, 4'd2);
    do_reset();
    idle(3);
    idle(4);
    do_reset();
    count_busy(16);
    op(1'b0, '0, '0, '0, 1'b1, 4'd8);
    op(1'b0, '0, '0, '0, 1'b1, 4'd15);
    drain();
  endtask

  task automatic test_random();
    for (int i = 0; i < 60; i++) begin
      op(1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)), DW'($urandom),
         NL'($urandom_range(0, 7)), 1'($urandom_range(0, 1)), AW'($urandom_range(0, DEPTH - 1)));
    end
    drain();
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_same_cycle();
    test_back_to_back();
    test_hold();
    test_busy_drop();
    test_reset_inflight();
    test_random();
    test_hold();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not finish, required completion");
    $fatal(1);
  end

endmodule
